// File: rtl/ram256_arbiter.sv
// Two-port round-robin front end for the ram256 64Kx32 memory: IDLE -> ISSUE -> CAPTURE -> DONE.
// Build option RAM256_ARB_WPROT_EN write-protects bank 3 against port B (errB flags the blocked write).
module ram256_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqA,
    input  logic        reqB,
    input  logic        weA,
    input  logic        weB,
    input  logic [15:0] addrA,
    input  logic [15:0] addrB,
    input  logic [31:0] wdataA,
    input  logic [31:0] wdataB,
    output logic        ackA,
    output logic        ackB,
    output logic [31:0] rdataA,
    output logic [31:0] rdataB,
    output logic        errA,
    output logic        errB,
    output logic        busy,
    output logic [15:0] addr16,
    output logic [31:0] dataIn,
    output logic        wrEnable,
    input  logic [31:0] dataOut
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic [1:0] state;
    logic       last;
    logic       gnt;
    logic       blocked;
    logic       grant_a;
    logic       grant_b;
    logic       protect;

    // Round robin: on a tie the port that was not served last wins.
    always_comb begin
        grant_a = reqA && (!reqB || (last == PORT_B));
        grant_b = reqB && !grant_a;
    end

`ifdef RAM256_ARB_WPROT_EN
    assign protect = weB && (addrB[15:14] == 2'b11);
`else
    assign protect = 1'b0;
`endif

    // Protection only ever applies to port B, so port A never reports an error.
    assign errA = 1'b0;
    assign busy = (state != IDLE);

    // addr16/dataIn double as the latched request: loaded on grant, held until the next grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= PORT_B;
            gnt      <= PORT_A;
            blocked  <= 1'b0;
            addr16   <= 16'h0000;
            dataIn   <= 32'h0;
            wrEnable <= 1'b0;
            ackA     <= 1'b0;
            ackB     <= 1'b0;
            errB     <= 1'b0;
            rdataA   <= 32'h0;
            rdataB   <= 32'h0;
        end else begin
            // NOTE: pulse outputs get a low default first, so any state that does not re-assert them clears them next edge.
            wrEnable <= 1'b0;
            ackA     <= 1'b0;
            ackB     <= 1'b0;
            errB     <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        gnt      <= grant_b ? PORT_B : PORT_A;
                        blocked  <= grant_b && protect;
                        addr16   <= grant_b ? addrB : addrA;
                        dataIn   <= grant_b ? wdataB : wdataA;
                        wrEnable <= grant_b ? (weB && !protect) : weA;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    // Sampled a full cycle after the address, so a registered ram256 read also lands here.
                    if (gnt == PORT_A) begin
                        rdataA <= dataOut;
                    end else begin
                        rdataB <= dataOut;
                    end
                    ackA  <= (gnt == PORT_A);
                    ackB  <= (gnt == PORT_B);
                    errB  <= (gnt == PORT_B) && blocked;
                    state <= DONE;
                end
                DONE: begin
                    last  <= gnt;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram256_arbiter.sv
// Self-checking bench for ram256_arbiter: directed scenarios plus randomized two-port traffic,
// scored against a word-level memory model through per-port expectation queues.
module tb_ram256_arbiter;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        reqA   = 1'b0;
    logic        reqB   = 1'b0;
    logic        weA    = 1'b0;
    logic        weB    = 1'b0;
    logic [15:0] addrA  = 16'h0;
    logic [15:0] addrB  = 16'h0;
    logic [31:0] wdataA = 32'h0;
    logic [31:0] wdataB = 32'h0;
    logic        ackA, ackB, errA, errB, busy, wrEnable;
    logic [31:0] rdataA, rdataB, dataIn, dataOut;
    logic [15:0] addr16;

`ifdef RAM256_ARB_WPROT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit port_b;
        int cyc;
    } ack_ev_t;

    exp_t        exp_a[$];
    exp_t        exp_b[$];
    ack_ev_t     ack_log[$];
    logic [31:0] ref_mem[int];
    bit   [31:0] ram[0:65535];

    int cycle     = 0;
    int wr_cycles = 0;
    int n_checks  = 0;
    int n_fail    = 0;

    ram256_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reqA     (reqA),
        .reqB     (reqB),
        .weA      (weA),
        .weB      (weB),
        .addrA    (addrA),
        .addrB    (addrB),
        .wdataA   (wdataA),
        .wdataB   (wdataB),
        .ackA     (ackA),
        .ackB     (ackB),
        .rdataA   (rdataA),
        .rdataB   (rdataB),
        .errA     (errA),
        .errB     (errB),
        .busy     (busy),
        .addr16   (addr16),
        .dataIn   (dataIn),
        .wrEnable (wrEnable),
        .dataOut  (dataOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Stand-in for ram256: synchronous write, combinational read.
    always @(posedge clk) if (wrEnable) ram[addr16] <= dataIn;
    assign dataOut = ram[addr16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_busy"},     busy,     32'h0);
        check({p, "_ackA"},     ackA,     32'h0);
        check({p, "_ackB"},     ackB,     32'h0);
        check({p, "_errA"},     errA,     32'h0);
        check({p, "_errB"},     errB,     32'h0);
        check({p, "_wrEnable"}, wrEnable, 32'h0);
        check({p, "_addr16"},   addr16,   32'h0);
        check({p, "_dataIn"},   dataIn,   32'h0);
        check({p, "_rdataA"},   rdataA,   32'h0);
        check({p, "_rdataB"},   rdataB,   32'h0);
    endtask

    // Reference model: apply one transaction in service order and queue the response it must produce.
    function automatic void model_txn(input bit pb, input logic we, input logic [15:0] addr,
                                      input logic [31:0] wd);
        exp_t e;
        bit   blk;
        blk    = PROT_ON && pb && we && (addr >= 16'hC000);
        e.we   = we;
        e.err  = blk;
        e.data = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 32'h0;
        if (we && !blk) ref_mem[int'(addr)] = wd;
        if (pb) exp_b.push_back(e);
        else    exp_a.push_back(e);
    endfunction

    function automatic logic [15:0] bank_addr(input int i);
        logic [1:0] b;
        b = i[1:0];
        return {b, 14'h0003};
    endfunction

    function automatic logic [15:0] rand_addr(input bit pb);
        logic [1:0] bank;
        logic [1:0] word;
        bank = 2'($urandom_range(0, 3));
        word = 2'($urandom_range(0, 3));
        return {bank, 11'h0, word, pb};
    endfunction

    // Monitor: score every ack against the head of that port's queue.
    task automatic score(input bit pb);
        exp_t e;
        int   depth;
        ack_log.push_back('{pb, cycle});
        depth = pb ? exp_b.size() : exp_a.size();
        if (pb) check("ackB_expected", 32'(depth > 0), 32'h1);
        else    check("ackA_expected", 32'(depth > 0), 32'h1);
        if (depth > 0) begin
            if (pb) begin
                e = exp_b.pop_front();
                check("errB", errB, e.err);
                if (!e.we) check("rdataB", rdataB, e.data);
            end else begin
                e = exp_a.pop_front();
                check("errA", errA, e.err);
                if (!e.we) check("rdataA", rdataA, e.data);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (wrEnable) wr_cycles++;
            if (rst_n && ackA) score(1'b0);
            if (rst_n && ackB) score(1'b1);
        end
    end

    // Present one request at a negedge, wait (bounded) for its ack, report latency in cycles.
    task automatic drive(input bit pb, input logic we, input logic [15:0] addr, input logic [31:0] wd,
                         input bit keep, output int lat);
        int c0;
        bit got;
        if (pb) begin
            reqB = 1'b1; weB = we; addrB = addr; wdataB = wd;
        end else begin
            reqA = 1'b1; weA = we; addrA = addr; wdataA = wd;
        end
        c0  = cycle;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (pb ? ackB : ackA) begin
                got = 1'b1;
                lat = cycle - c0;
            end
        end
        if (pb) check("ackB_arrived", 32'(got), 32'h1);
        else    check("ackA_arrived", 32'(got), 32'h1);
        if (!keep) begin
            if (pb) reqB = 1'b0;
            else    reqA = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, wr0, lat, lat_a, lat_b;
        bit seen_a;

        // Power-on reset values.
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous first requests: A wins the tie, B follows four cycles later.
        ack_log.delete();
        model_txn(1'b0, 1'b0, 16'h4003, 32'h0);
        model_txn(1'b1, 1'b0, 16'h8003, 32'h0);
        c0 = cycle;
        reqA = 1'b1; weA = 1'b0; addrA = 16'h4003;
        reqB = 1'b1; weB = 1'b0; addrB = 16'h8003;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check("tie_busy", busy, 32'(i != 4));
            if (ackA) reqA = 1'b0;
            if (ackB) reqB = 1'b0;
        end
        @(negedge clk);
        check("tie_ack_count", ack_log.size(), 32'd2);
        if (ack_log.size() == 2) begin
            check("tie_first_port", ack_log[0].port_b, 32'h0);
            check("tie_first_lat",  ack_log[0].cyc - c0, 32'd3);
            check("tie_second_port", ack_log[1].port_b, 32'h1);
            check("tie_second_lat", ack_log[1].cyc - c0, 32'd7);
        end

        // A write then read-back of the same word.
        wr0 = wr_cycles;
        model_txn(1'b0, 1'b1, 16'h0003, 32'hCAFECAFE);
        drive(1'b0, 1'b1, 16'h0003, 32'hCAFECAFE, 1'b0, lat);
        check("wr_ack_latency", lat, 32'd3);
        check("wr_pulse_cycles", wr_cycles - wr0, 32'd1);
        wr0 = wr_cycles;
        model_txn(1'b0, 1'b0, 16'h0003, 32'h0);
        drive(1'b0, 1'b0, 16'h0003, 32'h0, 1'b0, lat);
        check("rd_ack_latency", lat, 32'd3);
        check("rd_no_write", wr_cycles - wr0, 32'd0);

        // Reset during CAPTURE of an A read: abort, then the held request is served again.
        model_txn(1'b0, 1'b0, 16'h0003, 32'h0);
        reqA = 1'b1; weA = 1'b0; addrA = 16'h0003; wdataA = 32'h5555AAAA;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("mid_rst");
        rst_n = 1'b1;
        c0 = cycle;
        seen_a = 1'b0;
        for (int i = 0; i < 16 && !seen_a; i++) begin
            @(negedge clk);
            if (ackA) seen_a = 1'b1;
        end
        check("rst_reservice_ack", 32'(seen_a), 32'h1);
        check("rst_reservice_lat", cycle - c0, 32'd3);
        reqA = 1'b0;
        @(negedge clk);

        // Continuous contention: B writes each bank, A reads each back; acks must alternate.
        pulse_reset();
        ack_log.delete();
        model_txn(1'b0, 1'b0, 16'h0010, 32'h0);
        for (int i = 0; i < 4; i++) begin
            model_txn(1'b1, 1'b1, bank_addr(i), 32'hBEBEBEBE);
            model_txn(1'b0, 1'b0, bank_addr(i), 32'h0);
        end
        fork
            begin
                drive(1'b0, 1'b0, 16'h0010, 32'h0, 1'b1, lat_a);
                for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, bank_addr(i), 32'h0, i < 3, lat_a);
            end
            begin
                for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, bank_addr(i), 32'hBEBEBEBE, i < 3, lat_b);
            end
        join
        @(negedge clk);
        check("rr_ack_count", ack_log.size(), 32'd9);
        for (int i = 0; i < ack_log.size() && i < 9; i++) begin
            check("rr_port_order", ack_log[i].port_b, 32'(i % 2));
            if (i > 0) check("rr_ack_spacing", ack_log[i].cyc - ack_log[i-1].cyc, 32'd4);
        end

        // Port B write into bank 3, then A reads it and overwrites it.
        wr0 = wr_cycles;
        model_txn(1'b1, 1'b1, 16'hC003, 32'h12345678);
        drive(1'b1, 1'b1, 16'hC003, 32'h12345678, 1'b0, lat);
        check("bank3_b_lat", lat, 32'd3);
        check("bank3_b_wr_pulse", wr_cycles - wr0, PROT_ON ? 32'd0 : 32'd1);
        model_txn(1'b0, 1'b0, 16'hC003, 32'h0);
        drive(1'b0, 1'b0, 16'hC003, 32'h0, 1'b0, lat);
        wr0 = wr_cycles;
        model_txn(1'b0, 1'b1, 16'hC003, 32'hA0A0C003);
        drive(1'b0, 1'b1, 16'hC003, 32'hA0A0C003, 1'b0, lat);
        check("bank3_a_wr_pulse", wr_cycles - wr0, 32'd1);
        model_txn(1'b0, 1'b0, 16'hC003, 32'h0);
        drive(1'b0, 1'b0, 16'hC003, 32'h0, 1'b0, lat);

        // Randomized concurrent traffic; the address LSB keeps the two ports' words disjoint.
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic        we;
                    logic [15:0] ad;
                    logic [31:0] wd;
                    bit          keep;
                    we   = 1'($urandom_range(0, 1));
                    ad   = rand_addr(1'b0);
                    wd   = $urandom();
                    keep = (i < 23) && ($urandom_range(0, 1) == 1);
                    model_txn(1'b0, we, ad, wd);
                    drive(1'b0, we, ad, wd, keep, lat_a);
                    if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    logic        we;
                    logic [15:0] ad;
                    logic [31:0] wd;
                    bit          keep;
                    we   = 1'($urandom_range(0, 1));
                    ad   = rand_addr(1'b1);
                    wd   = $urandom();
                    keep = (i < 23) && ($urandom_range(0, 1) == 1);
                    model_txn(1'b1, we, ad, wd);
                    drive(1'b1, we, ad, wd, keep, lat_b);
                    if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join

        repeat (4) @(negedge clk);
        check("exp_a_drained", exp_a.size(), 32'd0);
        check("exp_b_drained", exp_b.size(), 32'd0);
        check("idle_at_end", busy, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
